// File: rtl/prio_pkg.sv
// Shared definitions for the round-robin / fixed-priority request encoder.
package prio_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/prio_pick.sv
// Combinational winner search: lowest set request at or after 'start', wrapping.
module prio_pick #(
  parameter int unsigned N = 16,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [0:N-1] req,
  input  logic [W-1:0] start,
  output logic         hit,
  output logic [W-1:0] sel,
  output logic         multi
);

  logic [N-1:0] flat;
  logic [0:N-1] rot;
  logic [W-1:0] off;

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign flat  = req;
  assign multi = |(flat & (flat - N'(1)));

  always_comb begin
    rot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      rot[k] = req[start + W'(k)];
    end
  end

  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!hit && rot[k]) begin
        hit = 1'b1;
        off = W'(k);
      end
    end
  end

  assign sel = start + off;

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with fixed or round-robin arbitration and a valid/ready output.
module prio_encoder_rr
  import prio_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:N-1] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic [W-1:0] idx,
  output logic         valid,
  output logic         multi,
  output logic [W-1:0] ptr
);

  logic         load;
  logic         rr;
  logic         hit;
  logic         pick_multi;
  logic [W-1:0] sel;
  logic [W-1:0] start;

  assign load  = !valid || out_ready;
  assign rr    = (mode_e'(mode) == MODE_RR);
  assign start = rr ? ptr : '0;

  prio_pick #(
    .N(N),
    .W(W)
  ) u_pick (
    .req  (req),
    .start(start),
    .hit  (hit),
    .sel  (sel),
    .multi(pick_multi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      valid <= 1'b0;
      multi <= 1'b0;
      ptr   <= '0;
    end else if (load) begin
      if (hit) begin
        idx   <= sel;
        valid <= 1'b1;
        multi <= pick_multi;
        if (rr) ptr <= sel + W'(1);
      end else begin
        // Empty request: drop valid but keep the last index visible.
        valid <= 1'b0;
        multi <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr: directed scenarios plus random traffic against a reference model.
module tb_prio_encoder_rr;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [0:N-1] req = '0;
  logic         mode = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] idx;
  logic         valid;
  logic         multi;
  logic [W-1:0] ptr;

  prio_encoder_rr #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .mode     (mode),
    .out_ready(out_ready),
    .idx      (idx),
    .valid    (valid),
    .multi    (multi),
    .ptr      (ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit valid;
    bit multi;
    int ptr;
    int id;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_step = 0;

  int m_idx, m_ptr;
  bit m_valid, m_multi;

  task automatic check(input string name, input int act, input int req_val);
    n_cmp++;
    if (act != req_val) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req_val, $time);
    end
  endtask

  function automatic void model_reset();
    m_idx = 0; m_ptr = 0; m_valid = 0; m_multi = 0;
  endfunction

  // Reference: walk the source list in arbitration order and take the first requester.
  function automatic void model_step();
    int start, w;
    if (!m_valid || out_ready) begin
      if (req == '0) begin
        m_valid = 0;
        m_multi = 0;
      end else begin
        start = mode ? m_ptr : 0;
        w = -1;
        for (int o = 0; o < N; o++) begin
          if (w < 0 && req[(start + o) % N]) w = (start + o) % N;
        end
        m_idx   = w;
        m_valid = 1;
        m_multi = ($countones(req) > 1);
        if (mode) m_ptr = (w + 1) % N;
      end
    end
  endfunction

  // Inputs are set before calling; expectation is posted after the edge it describes.
  task automatic cycle();
    exp_t e;
    model_step();
    e.idx = m_idx; e.valid = m_valid; e.multi = m_multi; e.ptr = m_ptr; e.id = n_step++;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_idx"},   int'(idx),   0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_multi"}, int'(multi), 0);
    check({tag, "_ptr"},   int'(ptr),   0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_state("rst_async");
    model_reset();
    @(negedge clk);
    check_reset_state("rst_held");
    #1 rst = 1'b0;
  endtask

  function automatic logic [0:N-1] onehot(input int i);
    logic [0:N-1] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [0:N-1] three_bits();
    logic [0:N-1] v;
    v = '0;
    v[3] = 1'b1; v[7] = 1'b1; v[12] = 1'b1;
    return v;
  endfunction

  // Monitor: each cycle's DUT output is compared against the oldest posted expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("s%0d_valid", e.id), int'(valid), int'(e.valid));
      check($sformatf("s%0d_multi", e.id), int'(multi), int'(e.multi));
      check($sformatf("s%0d_idx",   e.id), int'(idx),   e.idx);
      check($sformatf("s%0d_ptr",   e.id), int'(ptr),   e.ptr);
    end
  end

  initial begin
    logic [0:N-1] wrapv;
    model_reset();
    rst = 1'b1; mode = 1'b0; out_ready = 1'b1; req = '0;
    repeat (2) @(negedge clk);
    check_reset_state("rst_init");
    #1 rst = 1'b0;

    // One-hot sweep, fixed priority.
    for (int i = 0; i < N; i++) begin
      req = onehot(i);
      cycle();
    end

    // Fixed priority, multi-hot held.
    req = three_bits();
    repeat (3) cycle();

    // Round-robin rotation from a fresh pointer.
    do_reset();
    mode = 1'b1;
    req = three_bits();
    repeat (4) cycle();

    // Backpressure: stalled output ignores request changes.
    mode = 1'b0;
    req = onehot(5);
    cycle();
    out_ready = 1'b0;
    cycle();
    req = onehot(9);
    repeat (3) cycle();
    out_ready = 1'b1;
    cycle();
    req = '0;
    cycle();
    cycle();

    // Pointer wrap then asynchronous reset while holding a grant.
    mode = 1'b1;
    req = onehot(14);
    cycle();
    wrapv = '0;
    wrapv[15] = 1'b1; wrapv[1] = 1'b1;
    req = wrapv;
    cycle();
    cycle();
    do_reset();

    // Random traffic, both modes, random backpressure.
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        0: req = '0;
        1: req = onehot($urandom_range(0, N - 1));
        default: req = (N)'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    req = '0;
    out_ready = 1'b1;
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    #1;
    check("drain_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised N-to-log2(N) priority encoder with a registered output stage and a valid/ready handshake.
- Selectable fixed-priority or round-robin arbitration, plus a multi-hot flag.
- Generalises the 16-to-4 one-hot encoder into an arbitration front-end for request vectors from interrupt or bus-request sources.
- Downstream consumers take one winning index per handshake.

Parameters:
- N, 16, number of request inputs; legal range is N >= 2 and a power of two.
- W, $clog2(N), width of the index output; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  level request vector; bit i is source i; source 0 is the leftmost/MSB position of the vector.
- mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- out_ready  in  1  downstream accepts idx this cycle.
- idx  out  W  registered winning source index.
- valid  out  1  idx holds a winner.
- multi  out  1  the vector captured with idx had more than one bit set.
- ptr  out  W  current round-robin start pointer; observability only.

Behaviour:
- Reset (asynchronous, immediate):
  - idx = 0, valid = 0, multi = 0, ptr = 0.
  - The first load after reset deassertion occurs at the first rising edge.
- Load condition: load = (!valid) | (valid & out_ready), evaluated each rising edge.
- On a load edge with req != 0:
  - idx = winner.
  - valid = 1.
  - multi = (popcount(req) > 1).
- On a load edge with req == 0: valid = 0, multi = 0, idx holds its previous value.
- When not loading (valid & !out_ready):
  - idx, valid and multi hold.
  - req changes are ignored and there is no re-evaluation.
- Winner selection, fixed mode (mode = 0): lowest set index in req.
- Winner selection, round-robin mode (mode = 1):
  - Scan indices ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - The first set index wins.
- Pointer update: on a load edge with a winner in mode 1, ptr = (winner + 1) mod N. Wrap from N-1 to 0 is natural W-bit overflow.
- In mode 0, ptr holds.
- mode is sampled at the load edge only. Switching mode does not reset ptr.
- Latency: req to idx/valid is 1 cycle when the output stage is empty or being accepted.
- Back-to-back throughput: one index per cycle while out_ready = 1.
- Requests are level-sensitive. A source that keeps req[i] high after its grant is re-granted per the arbitration policy:
  - fixed mode: it can starve higher indices;
  - round-robin mode: it is fair, with a worst-case wait of N-1 grants.
- Simultaneous out_ready and req change: the new req is captured on the same edge the old idx is accepted.
- Reset asserted mid-handshake: the pending idx is dropped and valid falls immediately. No grant is carried across reset.
- All outputs are driven from flops; there is no combinational req->idx path.

Decomposition:
- Package prio_pkg:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1;
  - a function for clog2 if the tool lacks $clog2.
- Sub-module prio_pick (purely combinational), parameters N and W:
  - inputs req[N] and start[W];
  - outputs hit, sel[W] and multi.
  - Implementation: rotate req by start, lowest-set-bit search, un-rotate the index.
  - Fixed mode drives start = 0.
- Top level holds the output register, the ptr register and the load logic.

Test Plan:
- Reset / one-hot sweep:
  - Stimulus: rst=1 then release; mode=0, out_ready=1; drive each one-hot req (bit 0 first, then bit 1, ..., bit 15), one per cycle.
  - Response: during reset idx=0, valid=0. Then idx = 0, 1, ..., 15, each 1 cycle after its input, with valid=1 and multi=0 throughout.
- Fixed priority, multi-hot:
  - Stimulus: mode=0; req has bits 3, 7 and 12 set; hold for 3 cycles with out_ready=1.
  - Response: idx=3 every cycle, multi=1, ptr stays 0.
- Round-robin rotation:
  - Stimulus: mode=1 from reset; same req (bits 3, 7, 12); out_ready=1; hold for 4 cycles.
  - Response: idx sequence 3, 7, 12, 3; ptr sequence 4, 8, 13, 4; multi=1.
- Backpressure:
  - Stimulus: req = bit 5 only; out_ready=0 for 4 cycles; switch req to bit 9 during the stall; then out_ready=1.
  - Response: idx=5 with valid=1 held for the whole stall. On the accept edge idx becomes 9. Next cycle, with req=0, valid=0 and idx stays 9.
- Wrap and mid-operation reset:
  - Stimulus: mode=1; req has bits 15 and 1 set, starting from ptr=15. Then assert rst asynchronously mid-cycle while valid=1.
  - Response: idx=15 and ptr wraps to 0; next grant idx=1, ptr=2. On rst, valid and ptr drop to 0 immediately, without waiting for a clock edge.
